// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and constants
package core_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int BYTE_WIDTH          = 8;
  localparam int MEM_BE_WIDTH        = DATA_WIDTH / BYTE_WIDTH;
  localparam int DATA_MEM_ADDR_WIDTH = 10;
  localparam int ARB_MAX_WAIT        = 3;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_DM   = 2'd2
  } resp_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
module mem_arbiter #(
  parameter int DATA_WIDTH = core_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = core_pkg::DATA_MEM_ADDR_WIDTH,
  parameter int MAX_WAIT   = core_pkg::ARB_MAX_WAIT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            if_req_i,
  input  logic [ADDR_WIDTH-1:0]           if_addr_i,
  output logic                            if_gnt_o,
  output logic                            if_rvalid_o,
  output logic [DATA_WIDTH-1:0]           if_rdata_o,
  input  logic                            dm_req_i,
  input  logic                            dm_we_i,
  input  logic [core_pkg::MEM_BE_WIDTH-1:0] dm_be_i,
  input  logic [ADDR_WIDTH-1:0]           dm_addr_i,
  input  logic [DATA_WIDTH-1:0]           dm_wdata_i,
  output logic                            dm_gnt_o,
  output logic                            dm_rvalid_o,
  output logic [DATA_WIDTH-1:0]           dm_rdata_o,
  output logic                            mem_en_o,
  output logic [core_pkg::MEM_BE_WIDTH-1:0] mem_we_o,
  output logic [ADDR_WIDTH-1:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0]           mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]           mem_rdata_i
);

  import core_pkg::*;

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             force_if;
  resp_owner_e      state_q, state_d;

  assign force_if = (wait_cnt == CNT_W'(MAX_WAIT));

  // DM has priority unless IF has been denied MAX_WAIT cycles in a row.
  always_comb begin
    if_gnt_o = 1'b0;
    dm_gnt_o = 1'b0;
    if (rst_n) begin
      if (dm_req_i && !(if_req_i && force_if)) begin
        dm_gnt_o = 1'b1;
      end else if (if_req_i) begin
        if_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (dm_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
      mem_we_o    = dm_we_i ? dm_be_i : '0;
    end else if (if_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = if_addr_i;
      mem_wdata_o = dm_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!if_req_i || if_gnt_o) begin
      wait_cnt <= '0;
    end else if (!force_if) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESP_NONE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stores complete at grant, so only loads and fetches own a response slot.
  always_comb begin
    state_d = RESP_NONE;
    if (if_gnt_o) begin
      state_d = RESP_IF;
    end else if (dm_gnt_o && !dm_we_i) begin
      state_d = RESP_DM;
    end
  end

  assign if_rvalid_o = (state_q == RESP_IF);
  assign dm_rvalid_o = (state_q == RESP_DM);
  assign if_rdata_o  = mem_rdata_i;
  assign dm_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_i = 1'b0;
  logic [9:0]  if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [3:0]  dm_be_i = '0;
  logic [9:0]  dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic        dm_gnt_o, dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_dm;
    logic [31:0] data;
  } resp_t;
  resp_t sb[$];

  logic [31:0] mem [1024];

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Memory macro: registered read, byte-masked write.
  always @(posedge clk) begin
    if (mem_en_o) begin
      mem_rdata_i <= mem[mem_addr_o];
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) mem[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
    end
  end

  always @(negedge clk) begin
    if (if_rvalid_o && dm_rvalid_o) begin
      checks++; errors++;
      $display("FAIL both_rvalid: if_rvalid=1 dm_rvalid=1, required at most one");
    end else if (if_rvalid_o || dm_rvalid_o) begin
      resp_t e;
      logic [31:0] got;
      checks++;
      got = dm_rvalid_o ? dm_rdata_o : if_rdata_o;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: if=%0b dm=%0b data=%h, required no response",
                 if_rvalid_o, dm_rvalid_o, got);
      end else begin
        e = sb.pop_front();
        if (e.is_dm != dm_rvalid_o || got !== e.data) begin
          errors++;
          $display("FAIL response: dm_port=%0b data=%h, required dm_port=%0b data=%h",
                   dm_rvalid_o, got, e.is_dm, e.data);
        end
      end
    end
  end

  task automatic expect_resp(input bit is_dm, input logic [31:0] data);
    resp_t e;
    e.is_dm = is_dm;
    e.data  = data;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One cycle: drive requests, then check grants and memory drive.
  task automatic cyc(input string name,
                     input logic ir, input logic [9:0] ia,
                     input logic dr, input logic dw, input logic [3:0] db,
                     input logic [9:0] da, input logic [31:0] dd,
                     input logic eig, input logic edg, input logic een,
                     input logic [3:0] ewe, input logic [9:0] ea);
    @(posedge clk);
    #1;
    if_req_i = ir; if_addr_i = ia;
    dm_req_i = dr; dm_we_i = dw; dm_be_i = db; dm_addr_i = da; dm_wdata_i = dd;
    #1;
    check(name, {15'd0, if_gnt_o, dm_gnt_o, mem_en_o, mem_we_o, mem_addr_o},
                {15'd0, eig, edg, een, ewe, ea});
  endtask

  task automatic idle(input string name);
    cyc(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 10'h0);
  endtask

  initial begin
    bit dm_exp [6] = '{1, 1, 1, 0, 1, 1};
    int k;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h004] = 32'h00500093;
    mem[10'h010] = 32'hAAAA0010;
    mem[10'h100] = 32'hBBBB0100;
    mem[10'h020] = 32'h11111111;
    mem[10'h030] = 32'h0FF00030;
    for (int i = 0; i < 6; i++) mem[10'h200 + i] = 32'hC0DE0000 + i;

    #2;
    check("reset_outputs", {26'd0, if_gnt_o, dm_gnt_o, mem_en_o, if_rvalid_o, dm_rvalid_o, |mem_we_o}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // IF alone
    cyc("if_only", 1, 10'h004, 0, 0, 0, 0, 0, 1, 0, 1, 4'h0, 10'h004);
    expect_resp(0, 32'h00500093);
    idle("if_only_after");

    // Simultaneous: DM first, then IF
    cyc("both_dm_first", 1, 10'h010, 1, 0, 4'hF, 10'h100, 0, 0, 1, 1, 4'h0, 10'h100);
    expect_resp(1, 32'hBBBB0100);
    cyc("both_if_next", 1, 10'h010, 0, 0, 0, 0, 0, 1, 0, 1, 4'h0, 10'h010);
    expect_resp(0, 32'hAAAA0010);
    idle("both_after");

    // Partial store then read back
    cyc("store", 0, 0, 1, 1, 4'b0011, 10'h020, 32'hDEADBEEF, 0, 1, 1, 4'b0011, 10'h020);
    check("store_wdata", mem_wdata_o, 32'hDEADBEEF);
    idle("store_after");
    cyc("load_back", 0, 0, 1, 0, 4'hF, 10'h020, 0, 0, 1, 1, 4'h0, 10'h020);
    expect_resp(1, 32'h1111BEEF);
    idle("load_back_after");

    // Starvation: IF forced through on the 4th denied cycle
    k = 0;
    for (int c = 0; c < 6; c++) begin
      if (dm_exp[c]) begin
        cyc($sformatf("starve_c%0d", c + 1), 1, 10'h030, 1, 0, 4'hF, 10'h200 + k, 0,
            0, 1, 1, 4'h0, 10'h200 + k);
        expect_resp(1, 32'hC0DE0000 + k);
        k++;
      end else begin
        cyc($sformatf("starve_c%0d", c + 1), 1, 10'h030, 1, 0, 4'hF, 10'h200 + k, 0,
            1, 0, 1, 4'h0, 10'h030);
        expect_resp(0, 32'h0FF00030);
      end
    end
    idle("starve_after");

    // Reset while a load response is pending
    cyc("rst_grant", 0, 0, 1, 0, 4'hF, 10'h100, 0, 0, 1, 1, 4'h0, 10'h100);
    @(posedge clk);
    #1;
    if_req_i = 1'b1; rst_n = 1'b0;
    #1;
    check("rst_outputs", {26'd0, if_gnt_o, dm_gnt_o, mem_en_o, if_rvalid_o, dm_rvalid_o, |mem_we_o}, 32'd0);
    @(posedge clk); #1;
    check("rst_held", {26'd0, if_gnt_o, dm_gnt_o, mem_en_o, if_rvalid_o, dm_rvalid_o, |mem_we_o}, 32'd0);
    if_req_i = 1'b0; dm_req_i = 1'b0; rst_n = 1'b1;
    idle("rst_release");

    // Idle run
    for (int c = 0; c < 10; c++) begin
      idle("idle_grants");
      check("idle_outputs", {27'd0, mem_en_o, mem_we_o != 4'h0, if_rvalid_o, dm_rvalid_o, 1'b0}, 32'd0);
    end

    @(posedge clk); @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-port synchronous unified memory (1024 x 32-bit words) between two requesters: instruction fetch (IF) and the load/store stage (DM).
- Grants at most one access per cycle, with priority to DM and an IF anti-starvation counter.
- Routes each read response back to its owner one cycle after the grant.
- Sits between the core pipeline and the memory macro.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 10, word address width (equals DATA_MEM_ADDR_WIDTH).
- MAX_WAIT, 3, consecutive denied IF cycles before IF is forced to win.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- if_req_i  input  1  IF read request; held until granted
- if_addr_i  input  ADDR_WIDTH  IF word address
- if_gnt_o  output  1  IF request accepted this cycle
- if_rvalid_o  output  1  IF read data valid
- if_rdata_o  output  DATA_WIDTH  IF read data
- dm_req_i  input  1  DM request; held until granted
- dm_we_i  input  1  1 = store, 0 = load
- dm_be_i  input  4  store byte enables
- dm_addr_i  input  ADDR_WIDTH  DM word address
- dm_wdata_i  input  DATA_WIDTH  store data (pre-aligned to byte lanes)
- dm_gnt_o  output  1  DM request accepted this cycle
- dm_rvalid_o  output  1  DM load data valid
- dm_rdata_o  output  DATA_WIDTH  DM load data
- mem_en_o  output  1  memory access enable
- mem_we_o  output  4  memory byte write enables
- mem_addr_o  output  ADDR_WIDTH  memory address
- mem_wdata_o  output  DATA_WIDTH  memory write data
- mem_rdata_i  input  DATA_WIDTH  memory read data, valid the cycle after an enabled read

Behaviour:
- One clock (clk). Reset rst_n is asynchronous, active-low.
- Reset values: resp_owner = RESP_NONE, wait_cnt = 0, if_rvalid_o = 0, dm_rvalid_o = 0.
- While rst_n = 0: if_gnt_o, dm_gnt_o, mem_en_o and mem_we_o are forced to 0.
- Grant is combinational in the request cycle:
  - force_if = (wait_cnt == MAX_WAIT).
  - Only one requester: it wins.
  - Both requesting: DM wins unless force_if, in which case IF wins.
  - No request: no grant, mem_en_o = 0.
- Memory drive from the winner, same cycle:
  - mem_en_o = 1; mem_addr_o = winner address.
  - mem_we_o = dm_be_i if the DM winner is a store, else 0.
  - mem_wdata_o = dm_wdata_i.
  - With no winner, mem_addr_o, mem_wdata_o and mem_we_o are 0.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - Increments when if_req_i = 1 and if_gnt_o = 0; saturates at MAX_WAIT.
  - Clears to 0 on if_gnt_o, or when if_req_i = 0.
- Response-owner FSM, registered, states RESP_NONE / RESP_IF / RESP_DM:
  - Next state is RESP_IF on an IF grant.
  - RESP_DM on a DM load grant.
  - RESP_NONE on a DM store grant or no grant.
  - Transitions every cycle; no waits.
- Outputs from the FSM:
  - if_rvalid_o = (state == RESP_IF); dm_rvalid_o = (state == RESP_DM).
  - Both rdata outputs carry mem_rdata_i unconditionally; consumers qualify with rvalid.
- Latency: grant in cycle N, rvalid and data in cycle N+1. Stores complete at grant; no response.
- Back-to-back accesses are full throughput (one per cycle). A response for cycle N's read coexists with a new grant in cycle N+1.
- Requester contract: req, addr, we, be and wdata stay stable until gnt. The arbiter does not check this.
- Reset asserted mid-operation: a pending response is discarded (rvalid = 0 immediately), and wait_cnt clears.
- dm_be_i = 0 on a store: still granted; mem_we_o = 0 (no-op write).

Decomposition:
- Shared package core_pkg gets:
  - resp_owner_e enum {RESP_NONE, RESP_IF, RESP_DM}.
  - MEM_BE_WIDTH = DATA_WIDTH/BYTE_WIDTH.
  - ARB_MAX_WAIT constant.
- ADDR_WIDTH defaults to DATA_MEM_ADDR_WIDTH.
- No sub-module needed; grant logic, counter and FSM fit in one module (~150 lines).

Test Plan:
1. IF only, if_req_i = 1, addr 0x004, memory holding 0x00500093 at that word -> if_gnt_o = 1 the same cycle, mem_en_o = 1, mem_addr_o = 0x004; next cycle if_rvalid_o = 1, if_rdata_o = 0x00500093, dm_rvalid_o = 0.
2. Simultaneous IF (addr 0x010) and DM load (addr 0x100) -> DM granted first, IF granted the following cycle; responses arrive dm_rvalid_o then if_rvalid_o on consecutive cycles with the correct data each.
3. DM store, addr 0x020, be = 4'b0011, wdata = 0xDEADBEEF -> mem_we_o = 4'b0011, no rvalid on either port; a later load of 0x020 over an old value 0x11111111 returns 0x1111BEEF.
4. Starvation: DM loads on 6 consecutive cycles with IF requesting throughout (MAX_WAIT = 3) -> IF granted in cycle 4; wait_cnt returns to 0; DM is granted again in cycle 5.
5. Reset mid-operation: grant a DM load, assert rst_n = 0 in the next cycle before the clock edge -> dm_rvalid_o drops to 0 immediately, grants are 0; after release with no requests, all outputs stay 0.
6. Idle: no requests for 10 cycles -> mem_en_o = 0, mem_we_o = 0, both rvalid outputs 0 throughout.
